axi_w_order_arbiter: RTL and testbench

- Shares the single master-side W-channel async FIFO write port between two AXI masters (M0, M1).
- Arbitrates AW handshakes round-robin and records the grant order plus burst length in an in-order queue.
- Steers W beats into the FIFO strictly in AW-grant order, as AXI requires, and regenerates WLAST from a beat counter.
- Sits in the ACLK domain on the write (push) side of the FIFO; the AW payload mux is a sibling block driven by aw_grant_o.

---
 rtl/axi_w_order_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_w_order_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_w_order_arbiter.sv
// ---------------------------------------------------------------------------
// axi_w_order_arbiter
//
// Purpose:
//   Shares the single W-channel async FIFO write port between two AXI masters
//   (M0, M1). AW handshakes are arbitrated round-robin and each grant is
//   recorded, with its burst length, in a small in-order queue. W beats are
//   then steered into the FIFO strictly in AW-grant order. WLAST is
//   regenerated from a beat counter, and the masters' own WLAST is only
//   checked against it.
//
// Ports:
//   ACLK, ARESETn     clock and asynchronous active-low reset
//   awvalid_i[m]      AW valid from master m
//   awlen_i           AWLEN per master, master m at [m*LEN_W +: LEN_W]
//   awready_o[m]      AW ready to master m (at most one bit high)
//   aw_grant_o        one-hot AW handshake indicator for the AW payload mux
//   wvalid_i/wdata_i/wstrb_i/wlast_i
//                     W channel from both masters, per-master slices
//   wready_o[m]       W ready to master m (only the current head master)
//   fifo_wdata_o      {last, strb, data} toward the FIFO write port
//   fifo_wpush_o      FIFO push strobe
//   fifo_wfull_i      FIFO full
//   w_err_o           sticky flag: a master's WLAST disagreed with AWLEN
//   busy_o            order queue holds at least one outstanding burst
// ---------------------------------------------------------------------------
module axi_w_order_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STRB_W     = 4,
  parameter int LEN_W      = 4,
  parameter int ORDQ_DEPTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [1:0]                 awvalid_i,
  input  logic [2*LEN_W-1:0]         awlen_i,
  output logic [1:0]                 awready_o,
  output logic [1:0]                 aw_grant_o,
  input  logic [1:0]                 wvalid_i,
  input  logic [2*DATA_W-1:0]        wdata_i,
  input  logic [2*STRB_W-1:0]        wstrb_i,
  input  logic [1:0]                 wlast_i,
  output logic [1:0]                 wready_o,
  output logic [DATA_W+STRB_W:0]     fifo_wdata_o,
  output logic                       fifo_wpush_o,
  input  logic                       fifo_wfull_i,
  output logic                       w_err_o,
  output logic                       busy_o
);

  localparam int PTR_W = (ORDQ_DEPTH > 1) ? $clog2(ORDQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Order queue: master id and AWLEN of each granted burst, oldest at rdPtr_q
  logic             ordId_q  [ORDQ_DEPTH];
  logic [LEN_W-1:0] ordLen_q [ORDQ_DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] beatCnt_q, beatCnt_d;
  logic             rrLast_q, rrLast_d;
  logic             wErr_q, wErr_d;

  logic             qNotFull;
  logic             winner;
  logic [1:0]       awReady;
  logic             awHs;
  logic [LEN_W-1:0] winLen;
  logic             headValid;
  logic             sel;
  logic [LEN_W-1:0] headLen;
  logic             expLast;
  logic             push;
  logic             pop;
  logic [DATA_W-1:0] selData;
  logic [STRB_W-1:0] selStrb;
  logic             selLast;

  // AW arbitration. Eligibility uses the registered count only, so a W pop in
  // the same cycle never frees a slot early. With both masters requesting,
  // the one that did not win last time gets the grant. Everything is gated
  // by ARESETn so the outputs read 0 while reset is held.
  always_comb begin
    awReady  = 2'b00;
    qNotFull = (count_q < CNT_W'(ORDQ_DEPTH));
    if (awvalid_i == 2'b11) begin
      winner = ~rrLast_q;
    end else begin
      winner = awvalid_i[1];
    end
    if (ARESETn && qNotFull && (awvalid_i != 2'b00)) begin
      awReady[winner] = 1'b1;
    end
    awHs   = |(awvalid_i & awReady);
    winLen = winner ? awlen_i[2*LEN_W-1:LEN_W] : awlen_i[LEN_W-1:0];
  end

  assign awready_o  = awReady;
  assign aw_grant_o = awvalid_i & awReady;

  // W steering: only the master at the head of the order queue is offered
  // wready. The FIFO last bit is the regenerated one, never the master's.
  always_comb begin
    headValid = (count_q != '0);
    sel       = ordId_q[rdPtr_q];
    headLen   = ordLen_q[rdPtr_q];
    expLast   = headValid && (beatCnt_q == headLen);
    selData   = sel ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
    selStrb   = sel ? wstrb_i[2*STRB_W-1:STRB_W] : wstrb_i[STRB_W-1:0];
    selLast   = sel ? wlast_i[1] : wlast_i[0];
    wready_o  = 2'b00;
    push      = 1'b0;
    fifo_wdata_o = '0;
    if (ARESETn && headValid) begin
      fifo_wdata_o = {expLast, selStrb, selData};
      if (!fifo_wfull_i) begin
        wready_o[sel] = 1'b1;
        push          = sel ? wvalid_i[1] : wvalid_i[0];
      end
    end
    pop = push && expLast;
  end

  assign fifo_wpush_o = push;
  assign busy_o       = (count_q != '0);
  assign w_err_o      = wErr_q;

  // Next-state for pointers, occupancy, beat counter and error flag. A pop
  // and an AW handshake in the same cycle cancel in the count.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    beatCnt_d = beatCnt_q;
    rrLast_d  = rrLast_q;
    wErr_d    = wErr_q;
    count_d   = count_q + CNT_W'(awHs) - CNT_W'(pop);
    if (awHs) begin
      wrPtr_d  = wrPtr_q + PTR_W'(1);
      rrLast_d = winner;
    end
    if (push) begin
      if (expLast) begin
        beatCnt_d = '0;
        rdPtr_d   = rdPtr_q + PTR_W'(1);
      end else begin
        beatCnt_d = beatCnt_q + LEN_W'(1);
      end
      if (selLast != expLast) begin
        wErr_d = 1'b1;
      end
    end
  end

  // State registers. rrLast resets to 1 so M0 wins the first contested grant.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      beatCnt_q <= '0;
      rrLast_q  <= 1'b1;
      wErr_q    <= 1'b0;
      for (int i = 0; i < ORDQ_DEPTH; i++) begin
        ordId_q[i]  <= 1'b0;
        ordLen_q[i] <= '0;
      end
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      beatCnt_q <= beatCnt_d;
      rrLast_q  <= rrLast_d;
      wErr_q    <= wErr_d;
      if (awHs) begin
        ordId_q[wrPtr_q]  <= winner;
        ordLen_q[wrPtr_q] <= winLen;
      end
    end
  end

endmodule

// File: tb/tb_axi_w_order_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_w_order_arbiter
//
// Purpose:
//   Self-checking bench for axi_w_order_arbiter. A behavioural model keeps the
//   outstanding bursts as a queue of {master, awlen} records and a plain beat
//   count for the head burst; every cycle all DUT outputs are compared with
//   what that model predicts. Directed scenarios come first, then a stretch
//   of randomized traffic.
// ---------------------------------------------------------------------------
module tb_axi_w_order_arbiter;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 4;
  localparam int FW     = DATA_W + STRB_W + 1;

  logic                  ACLK = 1'b0;
  logic                  ARESETn = 1'b0;
  logic [1:0]            awvalid_i = '0;
  logic [2*LEN_W-1:0]    awlen_i = '0;
  logic [1:0]            awready_o;
  logic [1:0]            aw_grant_o;
  logic [1:0]            wvalid_i = '0;
  logic [2*DATA_W-1:0]   wdata_i = '0;
  logic [2*STRB_W-1:0]   wstrb_i = '0;
  logic [1:0]            wlast_i = '0;
  logic [1:0]            wready_o;
  logic [FW-1:0]         fifo_wdata_o;
  logic                  fifo_wpush_o;
  logic                  fifo_wfull_i = 1'b0;
  logic                  w_err_o;
  logic                  busy_o;

  axi_w_order_arbiter #(
    .DATA_W(DATA_W), .STRB_W(STRB_W), .LEN_W(LEN_W), .ORDQ_DEPTH(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .awvalid_i(awvalid_i), .awlen_i(awlen_i),
    .awready_o(awready_o), .aw_grant_o(aw_grant_o),
    .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .wlast_i(wlast_i), .wready_o(wready_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_wpush_o(fifo_wpush_o),
    .fifo_wfull_i(fifo_wfull_i), .w_err_o(w_err_o), .busy_o(busy_o)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    int id;
    int len;
  } burst_t;
  burst_t ordq[$];
  int     beatM;
  int     rrLastM;
  bit     errM;

  // Model predictions for the current cycle
  int            winnerM;
  int            selM;
  bit            expLastM;
  logic [1:0]    expAwready;
  logic [1:0]    expGrant;
  logic [1:0]    expWready;
  logic          expPush;
  logic [FW-1:0] expData;
  logic          expBusy;
  logic          expErr;

  task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    ordq.delete();
    beatM   = 0;
    rrLastM = 1;
    errM    = 1'b0;
  endtask

  // Predict outputs from the current queue contents and the driven inputs
  task automatic modelEval();
    int n;
    n          = ordq.size();
    winnerM    = -1;
    expAwready = 2'b00;
    if (n < DEPTH) begin
      if (awvalid_i == 2'b11)      winnerM = (rrLastM == 0) ? 1 : 0;
      else if (awvalid_i == 2'b01) winnerM = 0;
      else if (awvalid_i == 2'b10) winnerM = 1;
    end
    if (winnerM >= 0) expAwready[winnerM] = 1'b1;
    expGrant  = awvalid_i & expAwready;
    expWready = 2'b00;
    expPush   = 1'b0;
    expData   = '0;
    expLastM  = 1'b0;
    selM      = 0;
    if (n > 0) begin
      selM     = ordq[0].id;
      expLastM = (beatM == ordq[0].len);
      expData  = {expLastM, wstrb_i[selM*STRB_W +: STRB_W], wdata_i[selM*DATA_W +: DATA_W]};
      if (!fifo_wfull_i) begin
        expWready[selM] = 1'b1;
        expPush         = wvalid_i[selM];
      end
    end
    expBusy = (n != 0);
    expErr  = errM;
  endtask

  // Advance the model across one clock edge using the cycle's predictions
  task automatic modelStep();
    if (expPush) begin
      if (wlast_i[selM] != expLastM) errM = 1'b1;
      if (expLastM) begin
        void'(ordq.pop_front());
        beatM = 0;
      end else begin
        beatM++;
      end
    end
    if (winnerM >= 0) begin
      ordq.push_back('{id: winnerM, len: int'(awlen_i[winnerM*LEN_W +: LEN_W])});
      rrLastM = winnerM;
    end
  endtask

  task automatic checkOutput();
    checkOne("awready", 64'(awready_o), 64'(expAwready));
    checkOne("aw_grant", 64'(aw_grant_o), 64'(expGrant));
    checkOne("wready", 64'(wready_o), 64'(expWready));
    checkOne("fifo_wpush", 64'(fifo_wpush_o), 64'(expPush));
    checkOne("fifo_wdata", 64'(fifo_wdata_o), 64'(expData));
    checkOne("busy", 64'(busy_o), 64'(expBusy));
    checkOne("w_err", 64'(w_err_o), 64'(expErr));
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle,
  // then move the model across the next rising edge.
  task automatic applyStimulus(input logic [1:0] awv, input logic [7:0] awl,
                               input logic [1:0] wv, input logic [1:0] wl,
                               input logic full);
    awvalid_i    = awv;
    awlen_i      = awl;
    wvalid_i     = wv;
    wlast_i      = wl;
    fifo_wfull_i = full;
    wdata_i      = {$urandom, $urandom};
    wstrb_i      = 8'($urandom);
    #2;
    modelEval();
    checkOutput();
    @(posedge ACLK);
    modelStep();
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOne({tag, "_awready"}, 64'(awready_o), 64'd0);
    checkOne({tag, "_grant"}, 64'(aw_grant_o), 64'd0);
    checkOne({tag, "_wready"}, 64'(wready_o), 64'd0);
    checkOne({tag, "_push"}, 64'(fifo_wpush_o), 64'd0);
    checkOne({tag, "_wdata"}, 64'(fifo_wdata_o), 64'd0);
    checkOne({tag, "_busy"}, 64'(busy_o), 64'd0);
    checkOne({tag, "_err"}, 64'(w_err_o), 64'd0);
  endtask

  initial begin
    logic [1:0] wl;
    modelReset();

    // Reset held with both masters requesting: every output must stay 0
    awvalid_i = 2'b11;
    wvalid_i  = 2'b11;
    #3;
    checkAllZero("reset");
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    $display("[TB] reset released");

    // Single M0 burst of 4 beats, last bit only on the 4th
    applyStimulus(2'b01, 8'h03, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b01, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);
    checkOne("t1_busy_after", 64'(busy_o), 64'd0);

    // Contested AW: M0 first, M1 next; M1's early W is stalled
    applyStimulus(2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b10, 8'h00, 2'b10, 2'b10, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b11, 2'b11, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b10, 2'b10, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);

    // Fill the order queue from M1; the 5th AW waits out the pop cycle
    repeat (4) applyStimulus(2'b10, 8'h00, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b10, 8'h00, 2'b10, 2'b10, 1'b0);
    checkOne("t3_full_busy", 64'(busy_o), 64'd1);
    applyStimulus(2'b10, 8'h00, 2'b00, 2'b00, 1'b0);
    repeat (4) applyStimulus(2'b00, 8'h00, 2'b10, 2'b10, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);

    // FIFO backpressure for 3 cycles in the middle of a 3-beat burst
    applyStimulus(2'b01, 8'h02, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b00, 1'b0);
    repeat (3) applyStimulus(2'b00, 8'h00, 2'b01, 2'b00, 1'b1);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b01, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);

    // WLAST on the wrong beat sets the sticky error
    applyStimulus(2'b01, 8'h01, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b01, 1'b0);
    checkOne("t5_err_set", 64'(w_err_o), 64'd1);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b01, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);
    checkOne("t5_err_sticky", 64'(w_err_o), 64'd1);

    // Asynchronous reset in the middle of a 4-beat burst
    applyStimulus(2'b01, 8'h03, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b01, 2'b00, 1'b0);
    awvalid_i = 2'b11;
    wvalid_i  = 2'b01;
    #2;
    ARESETn = 1'b0;
    #1;
    checkAllZero("midrst");
    modelReset();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    applyStimulus(2'b10, 8'h00, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b10, 2'b10, 1'b0);
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);
    checkOne("t6_err_clear", 64'(w_err_o), 64'd0);

    // Randomized traffic with correct WLAST from whichever master is at head
    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      wl = 2'($urandom);
      if (ordq.size() > 0) wl[ordq[0].id] = (beatM == ordq[0].len);
      applyStimulus(2'($urandom), 8'($urandom), 2'($urandom), wl,
                    ($urandom_range(0, 3) == 0));
    end
    repeat (3) applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
